// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that grants one of four requesters at a time and loads
// the winner's data lane into a single shared register, acknowledging each
// completed write. Transactions take three cycles: grant, write, gap.
module shared_reg_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   Q,
  output logic               busy,
  output logic [7:0]         wr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  // last: most recent completed writer; owner: requester holding the grant
  logic [1:0]       last;
  logic [1:0]       owner;
  logic [1:0]       win;
  logic [WIDTH-1:0] lane;
  logic             owner_req;

  // Search upward from last+1 with wrap; the smallest offset with req set wins.
  // Offset 4 (last itself) is checked first so it ends up lowest priority.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l;
    for (int i = 4; i >= 1; i--) begin
      idx = l + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  // Round-robin winner for the current request vector
  always_comb win = rr_pick(req, last);

  // Data lane and request bit of the granted requester
  always_comb begin
    lane = '0;
    for (int i = 0; i < 4; i++) begin
      if (owner == 2'(i)) lane = wdata[i*WIDTH +: WIDTH];
    end
    owner_req = req[owner];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: a dropped request during GRANT aborts back to IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|req) next_state = GRANT;
      GRANT:   next_state = owner_req ? DONE : IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Busy covers the whole grant/write/gap transaction
  always_comb busy = (state != IDLE);

  // Grant, write, acknowledge and bookkeeping registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= '0;
      ack      <= '0;
      Q        <= '0;
      wr_count <= '0;
      last     <= 2'd3;
      owner    <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          ack <= '0;
          if (|req) begin
            owner <= win;
            grant <= 4'b0001 << win;
          end
        end
        GRANT: begin
          grant <= '0;
          if (owner_req) begin
            Q        <= lane;
            ack      <= 4'b0001 << owner;
            last     <= owner;
            wr_count <= wr_count + 8'd1;
          end
        end
        DONE: begin
          ack <= '0;
        end
        default: begin
          grant <= '0;
          ack   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus
// randomized protocol-following traffic, compared every cycle against a
// transaction-level reference model.
module tb_shared_reg_arbiter;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = '0;
  logic [4*W-1:0] wdata = '0;
  logic [3:0]     grant;
  logic [3:0]     ack;
  logic [W-1:0]   Q;
  logic           busy;
  logic [7:0]     wr_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  shared_reg_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .ack(ack), .Q(Q), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: one transaction = pick, then write-or-abort, then gap.
  // phase 0 = waiting for a request, 1 = granted, 2 = post-write gap.
  int         m_phase = 0;
  int         m_owner = -1;
  int         m_gidx  = -1;
  int         m_aidx  = -1;
  int         m_last  = 3;
  int         m_cnt   = 0;
  logic [7:0] m_q     = '0;

  function automatic int pick(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++)
      if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_owner = -1; m_gidx = -1; m_aidx = -1;
      m_last = 3; m_cnt = 0; m_q = '0;
    end else begin
      case (m_phase)
        0: begin
          m_aidx = -1;
          if (req != 0) begin
            m_owner = pick(req, m_last);
            m_gidx = m_owner;
            m_phase = 1;
          end
        end
        1: begin
          m_gidx = -1;
          if (req[m_owner]) begin
            m_q = wdata[m_owner*W +: W];
            m_aidx = m_owner;
            m_last = m_owner;
            m_cnt = (m_cnt + 1) % 256;
            m_phase = 2;
          end else begin
            m_phase = 0;
          end
        end
        default: begin
          m_aidx = -1;
          m_phase = 0;
        end
      endcase
    end
  end

  function automatic logic [24:0] model_vec();
    logic [3:0] g, a;
    g = (m_gidx >= 0) ? (4'b0001 << m_gidx) : 4'b0000;
    a = (m_aidx >= 0) ? (4'b0001 << m_aidx) : 4'b0000;
    return {g, a, m_q, (m_phase != 0), m_cnt[7:0]};
  endfunction

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (!reset) begin
      vectors++;
      if ({grant, ack, Q, busy, wr_count} !== model_vec()) begin
        miscompares++;
        $display("FAIL model_cycle%0d: got grant=%b ack=%b Q=%h busy=%b cnt=%0d, expected {g,a,Q,busy,cnt}=%h",
                 cyc, grant, ack, Q, busy, wr_count, model_vec());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    wdata[i*W +: W] = v;
  endtask

  task automatic wait_ack(input string name);
    bit ok = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (ack != 0) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s_ack_timeout: got ack=%b expected nonzero", name, ack);
    end
  endtask

  task automatic wait_grant(input string name);
    bit ok = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (grant != 0) begin ok = 1; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s_grant_timeout: got grant=%b expected nonzero", name, grant);
    end
  endtask

  task automatic do_reset();
    req = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0] exp_q [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
  int         exp_i [5] = '{0, 1, 2, 3, 0};

  initial begin
    int ack_cyc, prev_cyc;
    logic [7:0] d;

    // Reset state
    @(negedge clk);
    check("reset_outputs", {7'd0, grant, ack, Q, busy, wr_count}, 32'h0);
    reset = 1'b0;

    // Single request from requester 0
    set_lane(0, 8'hA5);
    req = 4'b0001;
    @(negedge clk);
    check("t1_grant", grant, 4'b0001);
    check("t1_busy_g", busy, 1);
    @(negedge clk);
    check("t1_q", Q, 8'hA5);
    check("t1_ack", ack, 4'b0001);
    check("t1_grant_low", grant, 0);
    check("t1_busy_d", busy, 1);
    req = '0;
    @(negedge clk);
    check("t1_ack_low", ack, 0);
    check("t1_busy_low", busy, 0);
    check("t1_count", wr_count, 1);
    check("t1_model_cnt", m_cnt, 1);
    check("t1_model_q", m_q, 8'hA5);

    // Sustained contention from reset
    do_reset();
    set_lane(0, 8'h11); set_lane(1, 8'h22); set_lane(2, 8'h33); set_lane(3, 8'h44);
    req = 4'b1111;
    prev_cyc = 0;
    for (int n = 0; n < 5; n++) begin
      wait_ack("rr");
      ack_cyc = cyc;
      check($sformatf("rr_ack%0d", n), ack, 4'b0001 << exp_i[n]);
      check($sformatf("rr_q%0d", n), Q, exp_q[n]);
      if (n > 0) check($sformatf("rr_gap%0d", n), ack_cyc - prev_cyc, 3);
      prev_cyc = ack_cyc;
    end
    req = '0;
    @(negedge clk);

    // Abort: requester 2 drops during GRANT
    do_reset();
    set_lane(2, 8'h77);
    req = 4'b0100;
    wait_grant("abort");
    check("abort_grant", grant, 4'b0100);
    req = '0;
    @(negedge clk);
    check("abort_ack", ack, 0);
    check("abort_q", Q, 0);
    check("abort_cnt", wr_count, 0);
    check("abort_busy", busy, 0);
    check("abort_model_last", m_last, 3);
    set_lane(1, 8'h5A);
    req = 4'b0110;
    wait_grant("post_abort");
    check("post_abort_grant", grant, 4'b0010);
    wait_ack("post_abort");
    check("post_abort_q", Q, 8'h5A);
    req = '0;

    // Fairness: after requester 2 writes, 0101 goes to requester 0
    set_lane(2, 8'h66);
    req = 4'b0100;
    wait_ack("fair_w2");
    check("fair_ack2", ack, 4'b0100);
    set_lane(0, 8'h01);
    req = 4'b0101;
    wait_grant("fair");
    check("fair_grant", grant, 4'b0001);
    wait_ack("fair");
    check("fair_q", Q, 8'h01);
    req = '0;
    @(negedge clk);

    // Asynchronous reset between grant and write
    set_lane(3, 8'h3C);
    req = 4'b1000;
    wait_grant("midrst");
    check("midrst_grant", grant, 4'b1000);
    #1 reset = 1'b1;
    #1 check("midrst_outputs", {7'd0, grant, ack, Q, busy, wr_count}, 32'h0);
    @(negedge clk);
    check("midrst_nowrite_q", Q, 0);
    reset = 1'b0;
    wait_ack("midrst_after");
    check("midrst_after_ack", ack, 4'b1000);
    check("midrst_after_q", Q, 8'h3C);
    check("midrst_after_cnt", wr_count, 1);
    req = '0;

    // 256 completed writes wrap the counter
    do_reset();
    d = '0;
    for (int n = 0; n < 256; n++) begin
      d = 8'($urandom);
      wdata = '0;
      set_lane(n % 4, d);
      req = 4'b0001 << (n % 4);
      wait_ack("wrap");
      req = '0;
    end
    check("wrap_cnt", wr_count, 0);
    check("wrap_q", Q, d);
    @(negedge clk);

    // Randomized protocol-following traffic with occasional aborts
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) begin
          req[i] = $urandom_range(0, 1);
          if (req[i]) set_lane(i, 8'($urandom));
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_lane(i, 8'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
